// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Row-scan driver for an 8x8 LED matrix. One row advances per rising edge
//   of scan_clk, which comes from the upstream frequency divider and is
//   asynchronous to clk. Each row change is followed by BLANK_CYCLES clk
//   cycles with every output dark, to avoid ghosting. Column data comes from
//   a double-buffered frame store. Pattern logic writes the back buffer. The
//   buffers swap only at a frame boundary, so a frame never tears.
//
// Optional feature (compile-time macro LED_MATRIX_DIM_EN):
//   Adds the dim_level[3:0] input and a free-running 4-bit PWM counter.
//   While a row is driven, col_data is gated to zero whenever
//   pwm_cnt >= dim_level.
//
// Parameters
//   ROWS          number of matrix rows (power of two, >= 2)
//   COLS          number of columns (width of col_data / wr_data)
//   BLANK_CYCLES  clk cycles held dark after each row change (>= 1)
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   scan_clk   in   divided scan clock (asynchronous to clk)
//   wr_en      in   write wr_data into back-buffer row wr_row
//   wr_row     in   back-buffer row address (writes with wr_row >= ROWS ignored)
//   wr_data    in   row pattern, bit i = column i lit
//   swap_req   in   level request for a front/back swap, held until swap_ack
//   dim_level  in   brightness 0..15 (only with LED_MATRIX_DIM_EN)
//   swap_ack   out  1-cycle pulse when the swap takes effect
//   row_sel    out  one-hot active row, all-zero = blank
//   col_data   out  column drive for the active row
//   frame_done out  1-cycle pulse when the row index wraps ROWS-1 -> 0
module led_matrix_scanner #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_clk,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
`ifdef LED_MATRIX_DIM_EN
  input  logic [3:0]      dim_level,
`endif
  output logic            swap_ack,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic            frame_done
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = $clog2(BLANK_CYCLES + 1);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t          state, state_d;
  logic [RW-1:0]   row, row_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            front, front_d;
  logic            boundary;
  logic            swap_now;

  logic            scan_s1, scan_s2, scan_s3;
  logic            scan_tick;

  logic [COLS-1:0] frame_mem [2][ROWS];
  logic [RW-1:0]   wr_idx;
  logic            wr_ok;

  logic [ROWS-1:0] row_sel_d;
  logic [COLS-1:0] col_data_d;

`ifdef LED_MATRIX_DIM_EN
  logic [3:0]      pwm_cnt;
`endif

  // Two-flop synchronizer, then a registered rising-edge detect. This gives a
  // one-clk scan_tick three clk edges after scan_clk rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_s1   <= 1'b0;
      scan_s2   <= 1'b0;
      scan_s3   <= 1'b0;
      scan_tick <= 1'b0;
    end else begin
      scan_s1   <= scan_clk;
      scan_s2   <= scan_s1;
      scan_s3   <= scan_s2;
      scan_tick <= scan_s2 & ~scan_s3;
    end
  end

`ifdef LED_MATRIX_DIM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end
`endif

  // Frame store. Writes target the back buffer chosen by the current (pre-swap)
  // front, so a write in the swap cycle lands in the buffer that becomes front.
  assign wr_idx = RW'(wr_row);
  assign wr_ok  = wr_en && (32'(wr_row) < ROWS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          frame_mem[b][r] <= '0;
        end
      end
    end else if (wr_ok) begin
      frame_mem[~front][wr_idx] <= wr_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLANK;
      row   <= '0;
      cnt   <= '0;
      front <= 1'b0;
    end else begin
      state <= state_d;
      row   <= row_d;
      cnt   <= cnt_d;
      front <= front_d;
    end
  end

  // Next-state logic. The outputs are decoded from the next state and then
  // registered, so row_sel and col_data always change on the same edge.
  always_comb begin
    state_d    = state;
    row_d      = row;
    cnt_d      = cnt;
    front_d    = front;
    boundary   = 1'b0;
    swap_now   = 1'b0;
    row_sel_d  = '0;
    col_data_d = '0;

    case (state)
      ST_BLANK: begin
        // scan_tick is deliberately ignored here: the row only moves in DRIVE
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_d = ST_DRIVE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (scan_tick) begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          boundary = (row == RW'(ROWS - 1));
          row_d    = boundary ? '0 : row + 1'b1;
          swap_now = boundary && swap_req;
          if (swap_now) begin
            front_d = ~front;
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    if (state_d == ST_DRIVE) begin
      row_sel_d  = ROWS'(1) << row_d;
      col_data_d = frame_mem[front_d][row_d];
`ifdef LED_MATRIX_DIM_EN
      if (pwm_cnt >= dim_level) begin
        col_data_d = '0;
      end
`endif
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_sel    <= '0;
      col_data   <= '0;
      frame_done <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      row_sel    <= row_sel_d;
      col_data   <= col_data_d;
      frame_done <= boundary;
      swap_ack   <= swap_now;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner
//   Directed self-checking bench for led_matrix_scanner. A small model tracks
//   the row index, the front buffer and the contents of both buffers. Each scan
//   step pushes its expected outcome onto a scoreboard queue. The entry is
//   popped when the DUT lights the next row.
module tb_led_matrix_scanner;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int BLANK = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            scan_clk;
  logic            wr_en;
  logic [2:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic            swap_req;
  logic            swap_ack;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_done;
`ifdef LED_MATRIX_DIM_EN
  logic [3:0]      dim_level;
`endif

  led_matrix_scanner #(
    .ROWS(ROWS),
    .COLS(COLS),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scan_clk(scan_clk),
    .wr_en(wr_en),
    .wr_row(wr_row),
    .wr_data(wr_data),
    .swap_req(swap_req),
`ifdef LED_MATRIX_DIM_EN
    .dim_level(dim_level),
`endif
    .swap_ack(swap_ack),
    .row_sel(row_sel),
    .col_data(col_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string     tag;
    logic [7:0] rs;
    logic [7:0] cd;
    logic       fd;
    logic       sa;
    int         blank;
  } exp_t;

  exp_t sb[$];

  int         m_row;
  logic       m_front;
  logic [7:0] m_buf [2][ROWS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_row   = 0;
    m_front = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        m_buf[b][r] = 8'h00;
  endtask

  task automatic write_row(input int r, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_row  = r[2:0];
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    m_buf[m_front ^ 1'b1][r] = d;
  endtask

  // Model of one row advance. It reads swap_req as the bench currently drives it.
  task automatic expect_advance(input string tag);
    exp_t e;
    logic bnd;
    bnd = (m_row == ROWS - 1);
    if (bnd && swap_req) m_front = ~m_front;
    m_row   = (m_row + 1) % ROWS;
    e.tag   = tag;
    e.rs    = 8'(1 << m_row);
    e.cd    = m_buf[m_front][m_row];
    e.fd    = bnd;
    e.sa    = bnd && swap_req;
    e.blank = BLANK;
    sb.push_back(e);
  endtask

  // Drive `pulses` scan_clk pulses (2 clk high, 2 clk low). Watch the row go
  // dark and come back lit, then pop the scoreboard and compare.
  task automatic scan_step(input int pulses);
    int         blank = 0;
    logic       fd = 1'b0, sa = 1'b0, lit = 1'b0, glitch = 1'b0, seen_blank = 1'b0;
    logic [7:0] prs, pcd, obs_cd;
    exp_t       e;
    prs = row_sel;
    pcd = col_data;
    for (int cyc = 0; cyc < 60 && !lit; cyc++) begin
      scan_clk = (cyc < 4 * pulses) && ((cyc % 4) < 2);
      @(negedge clk);
      if (frame_done) fd = 1'b1;
      if (swap_ack) sa = 1'b1;
      if (row_sel == '0) begin
        blank++;
        seen_blank = 1'b1;
        if (col_data != '0) glitch = 1'b1;
      end else if (seen_blank) begin
        lit = 1'b1;
      end
`ifndef LED_MATRIX_DIM_EN
      else if (row_sel == prs && col_data != pcd) glitch = 1'b1;
`endif
      prs = row_sel;
      pcd = col_data;
    end
    scan_clk = 1'b0;
    obs_cd = col_data;
`ifdef LED_MATRIX_DIM_EN
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      obs_cd = obs_cd | col_data;
    end
`endif
    e = sb.pop_front();
    check({e.tag, "_lit"},        32'(lit),    32'd1);
    check({e.tag, "_row_sel"},    32'(row_sel), 32'(e.rs));
    check({e.tag, "_col_data"},   32'(obs_cd), 32'(e.cd));
    check({e.tag, "_frame_done"}, 32'(fd),     32'(e.fd));
    check({e.tag, "_swap_ack"},   32'(sa),     32'(e.sa));
    check({e.tag, "_blank"},      32'(blank),  32'(e.blank));
    check({e.tag, "_no_glitch"},  32'(glitch), 32'd0);
  endtask

  task automatic reset_release(input string tag);
    int n;
    rst      = 1'b1;
    scan_clk = 1'b0;
    wr_en    = 1'b0;
    swap_req = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_row_sel"},    32'(row_sel),    32'd0);
    check({tag, "_rst_col_data"},   32'(col_data),   32'd0);
    check({tag, "_rst_swap_ack"},   32'(swap_ack),   32'd0);
    check({tag, "_rst_frame_done"}, 32'(frame_done), 32'd0);
    rst = 1'b0;
    model_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (row_sel != '0) break;
    end
    check({tag, "_blank_len"}, 32'(n),        32'(BLANK));
    check({tag, "_first_row"}, 32'(row_sel),  32'h01);
    check({tag, "_first_col"}, 32'(col_data), 32'h00);
  endtask

  initial begin
    rst      = 1'b1;
    scan_clk = 1'b0;
    wr_en    = 1'b0;
    wr_row   = '0;
    wr_data  = '0;
    swap_req = 1'b0;
`ifdef LED_MATRIX_DIM_EN
    dim_level = 4'd15;
`endif

    // Reset release with scan_clk idle
    reset_release("t1");

    // Fill the back buffer and swap at the first frame boundary
    for (int r = 0; r < ROWS; r++) write_row(r, 8'h81);
    swap_req = 1'b1;
    for (int i = 0; i < ROWS; i++) begin
      expect_advance("t2");
      scan_step(1);
    end
    swap_req = 1'b0;

    // Continuous scan. Back-buffer writes stay invisible until the next swap,
    // and a swap requested mid-frame waits for the boundary.
    for (int i = 0; i < 3; i++) begin
      expect_advance("t3a");
      scan_step(1);
    end
    write_row(0, 8'h5A);
    for (int r = 1; r < ROWS; r++) write_row(r, 8'(r * 8'h11));
    swap_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_advance("t3b");
      scan_step(1);
    end
    swap_req = 1'b0;

    // Second scan_clk pulse lands while the DUT is blanking
    expect_advance("t4");
    scan_step(2);
    repeat (12) @(negedge clk);
    check("t4_no_skip", 32'(row_sel), 32'(8'(1 << m_row)));

    // Asynchronous reset while row 5 is lit
    for (int i = 0; i < 4; i++) begin
      expect_advance("t5a");
      scan_step(1);
    end
    check("t5_row5", 32'(row_sel), 32'h20);
    #2 rst = 1'b1;
    #1;
    check("t5_async_row_sel",  32'(row_sel),  32'd0);
    check("t5_async_col_data", 32'(col_data), 32'd0);
    @(negedge clk);
    reset_release("t5");
    for (int r = 0; r < ROWS; r++) write_row(r, 8'hFF);
    for (int i = 0; i < ROWS; i++) begin
      if (i == ROWS - 1) swap_req = 1'b1;
      expect_advance("t5b");
      scan_step(1);
    end
    swap_req = 1'b0;

`ifdef LED_MATRIX_DIM_EN
    // PWM dimming on row 0 (front = 0xFF)
    begin
      int bright, odd;
      dim_level = 4'd4;
      repeat (2) @(negedge clk);
      bright = 0;
      odd    = 0;
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        if (col_data == 8'hFF) bright++;
        else if (col_data != 8'h00) odd++;
      end
      check("t6_bright_lvl4", 32'(bright),  32'd8);
      check("t6_odd_lvl4",    32'(odd),     32'd0);
      check("t6_row_sel",     32'(row_sel), 32'h01);
      dim_level = 4'd0;
      repeat (2) @(negedge clk);
      bright = 0;
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        if (col_data != 8'h00) bright++;
      end
      check("t6_bright_lvl0", 32'(bright), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
